rca_seq_ctrl: RTL and testbench



---
 rtl/rca_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_rca_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer: runs one shared W-bit ripple-carry
// slice over N cycles to produce an N*W-bit result with a registered inter-slice carry.

module rca #(
   parameter int unsigned W = 16
) (
   output logic [W-1:0] sum,
   output logic         c_out,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in
);

   logic [W:0] c;

   // Bit-level ripple chain
   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = c_in;
      for (int i = 0; i < int'(W); i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign c_out = c[W];

endmodule

module rca_seq_ctrl #(
   parameter int unsigned W = 16,
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N*W-1:0] in_a,
   input  logic [N*W-1:0] in_b,
   input  logic           in_sub,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] sum,
   output logic           c_out,
   output logic           ovf,
   output logic           zero,
   output logic           busy
);

   localparam int unsigned DW    = N * W;
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [DW-1:0]   a_q;
   logic [DW-1:0]   b_q;
   logic            sub_q;
   logic            carry_q;
   logic [IDX_W-1:0] idx;

   logic [W-1:0]    a_slice;
   logic [W-1:0]    b_eff;
   logic            c_in;
   logic [W-1:0]    s_slice;
   logic            s_cout;
   logic [DW-1:0]   sum_next;
   logic            last;

   // Operand slice selection and result merge for the current index
   always_comb begin
      a_slice  = a_q[32'(idx) * W +: W];
      b_eff    = sub_q ? ~b_q[32'(idx) * W +: W] : b_q[32'(idx) * W +: W];
      c_in     = (idx == '0) ? sub_q : carry_q;
      sum_next = sum;
      sum_next[32'(idx) * W +: W] = s_slice;
      last     = (idx == IDX_W'(N - 1));
   end

   rca #(.W(W)) u_rca (
      .sum   (s_slice),
      .c_out (s_cout),
      .a     (a_slice),
      .b     (b_eff),
      .c_in  (c_in)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sub_q     <= 1'b0;
         carry_q   <= 1'b0;
         idx       <= '0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  a_q      <= in_a;
                  b_q      <= in_b;
                  sub_q    <= in_sub;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               sum     <= sum_next;
               carry_q <= s_cout;
               idx     <= IDX_W'(idx + 1'b1);
               if (last) begin
                  // Flags come from the top slice, which only exists in this cycle
                  c_out     <= s_cout;
                  ovf       <= (a_slice[W-1] == b_eff[W-1]) && (s_slice[W-1] != a_slice[W-1]);
                  zero      <= (sum_next == '0);
                  idx       <= '0;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for rca_seq_ctrl with hand-computed results.

module tb_rca_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] sum;
   logic        c_out;
   logic        ovf;
   logic        zero;
   logic        busy;

   int checks;
   int errors;

   rca_seq_ctrl #(.W(16), .N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf),
      .zero      (zero),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
      end
   endtask

   // Present a request and hold it through the accept edge
   task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s);
      int guard;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("issue_ready", 64'(in_ready), 64'd1);
      in_a     = a;
      in_b     = b;
      in_sub   = s;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count edges after the accept edge until out_valid, and busy samples on the way
   task automatic wait_result(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = busy ? 1 : 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cnt++;
      end
      if (!out_valid) check("timeout", 64'd0, 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic s, input logic [63:0] e_sum, input logic e_c,
                         input logic e_ovf, input logic e_zero);
      int lat;
      int bc;
      issue(a, b, s);
      wait_result(lat, bc);
      check({tag, "_lat"},  64'(lat), 64'd4);
      check({tag, "_busy"}, 64'(bc), 64'd4);
      check({tag, "_sum"},  sum, e_sum);
      check({tag, "_cout"}, 64'(c_out), 64'(e_c));
      check({tag, "_ovf"},  64'(ovf), 64'(e_ovf));
      check({tag, "_zero"}, 64'(zero), 64'(e_zero));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_drop"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      int lat;
      int bc;
      logic [63:0] held;
      logic        rdy_seen;
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      out_ready = 1'b0;

      #2;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_sum", sum, 64'd0);
      check("rst_flags", {60'd0, c_out, ovf, zero, busy}, 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", 64'(in_ready), 64'd1);

      run_op("add5_2",   64'd5, 64'd2, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
      run_op("carry16",  64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
      run_op("wrap",     64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      run_op("sub5_7",   64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      run_op("sub7_5",   64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
      run_op("sub_ovf",  64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
      run_op("add_ovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

      // Backpressure: result frozen, 1+1 offered but refused while in DONE
      issue(64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_0010, 1'b0);
      wait_result(lat, bc);
      held     = sum;
      check("bp_sum", held, 64'h1234_5678_9ABC_DF00);
      in_a     = 64'd1;
      in_b     = 64'd1;
      in_sub   = 1'b0;
      in_valid = 1'b1;
      rdy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (in_ready || !out_valid || sum !== held) rdy_seen = 1'b1;
      end
      check("bp_frozen", 64'(rdy_seen), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_idle_ready", 64'(in_ready), 64'd1);
      check("bp_idle_valid", 64'(out_valid), 64'd0);
      check("bp_no_accept", 64'(busy), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_accept", 64'(busy), 64'd1);
      wait_result(lat, bc);
      check("bp_lat", 64'(lat), 64'd4);
      check("bp_sum2", sum, 64'd2);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset after two slices have been written
      issue(64'h1111_2222_3333_4444, 64'd1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_low32", {32'd0, sum[31:0]}, 64'h0000_0000_3333_4445);
      rst_n = 1'b0;
      #1;
      check("mid_rst_sum", sum, 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_post_ready", 64'(in_ready), 64'd1);
      check("mid_no_valid", 64'(out_valid), 64'd0);
      run_op("add3_4", 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
